gyro_spi_reader: RTL

Periodic SPI burst reader for the IMU gyroscope. Every SAMPLE_PERIOD clocks it reads the six gyro output registers (X_H, X_L, Y_H, Y_L, Z_H, Z_L) in one burst and presents them as signed 16-bit gx/gy/gz with a one-cycle valid strobe. Sits directly upstream of process_gyro, which integrates gx/gy/gz into pitch/roll/yaw.

---
 rtl/gyro_spi_reader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/gyro_spi_reader.sv
// Periodic SPI burst reader: reads six gyro bytes every SAMPLE_PERIOD clocks and presents gx/gy/gz.
// Optional `GYRO_BIAS_EN: first 16 bursts calibrate a per-axis bias that is then subtracted.
module gyro_spi_reader #(
  parameter int unsigned CLK_DIV       = 50,
  parameter int unsigned SAMPLE_PERIOD = 100000,
  parameter logic [7:0]  START_REG     = 8'h43
) (
  input  logic        clk_100mhz,
  input  logic        rst_in,
  input  logic        miso_in,
  output logic        sclk_out,
  output logic        mosi_out,
  output logic        cs_n_out,
  output logic [15:0] gx,
  output logic [15:0] gy,
  output logic [15:0] gz,
  output logic        valid_out,
  output logic        busy_out,
  output logic        overrun_out
);

  // IDLE: wait for tick | SETUP: cs low before first edge | SHIFT: 56 SCLK periods | HOLD: cs low after last edge
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  localparam logic [7:0]  CMD         = {1'b1, START_REG[6:0]};
  localparam logic [31:0] PERIOD_LAST = 32'(SAMPLE_PERIOD - 1);
  localparam logic [7:0]  DIV_LOAD    = 8'(CLK_DIV - 1);

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [7:0]  timer;
  logic [5:0]  bit_cnt;
  logic [47:0] sr;
  logic        tick, tmr_done;
  logic [15:0] raw_x, raw_y, raw_z;

  assign tick     = (cnt == PERIOD_LAST);
  assign tmr_done = (timer == 8'd0);
  assign busy_out = ~cs_n_out;
  assign raw_x    = sr[47:32];
  assign raw_y    = sr[31:16];
  assign raw_z    = sr[15:0];

`ifdef GYRO_BIAS_EN
  logic signed [19:0] acc_x, acc_y, acc_z;
  logic [4:0]         cal_cnt;

  function automatic logic signed [19:0] sext(input logic [15:0] v);
    return $signed({{4{v[15]}}, v});
  endfunction
`endif

  always_ff @(posedge clk_100mhz or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = SETUP;
      SETUP:   if (tmr_done) state_nxt = SHIFT;
      SHIFT:   if (tmr_done && !sclk_out && bit_cnt == 6'd55) state_nxt = HOLD;
      HOLD:    if (tmr_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge rst_in) begin
    if (!rst_in) begin
      cnt         <= '0;
      timer       <= '0;
      bit_cnt     <= '0;
      sr          <= '0;
      sclk_out    <= 1'b0;
      mosi_out    <= 1'b0;
      cs_n_out    <= 1'b1;
      gx          <= '0;
      gy          <= '0;
      gz          <= '0;
      valid_out   <= 1'b0;
      overrun_out <= 1'b0;
`ifdef GYRO_BIAS_EN
      acc_x       <= '0;
      acc_y       <= '0;
      acc_z       <= '0;
      cal_cnt     <= '0;
`endif
    end else begin
      cnt         <= tick ? '0 : cnt + 32'd1;
      valid_out   <= 1'b0;
      overrun_out <= tick && (state != IDLE);
      if (state == IDLE) timer <= DIV_LOAD;
      else               timer <= tmr_done ? DIV_LOAD : timer - 8'd1;

      case (state)
        IDLE: if (tick) begin
          cs_n_out <= 1'b0;
          mosi_out <= CMD[7];
        end
        SETUP: if (tmr_done) begin
          sclk_out <= 1'b1;
          sr       <= {sr[46:0], miso_in};
          bit_cnt  <= '0;
        end
        SHIFT: if (tmr_done) begin
          if (sclk_out) begin
            sclk_out <= 1'b0;
            mosi_out <= (bit_cnt < 6'd7) ? CMD[3'd6 - bit_cnt[2:0]] : 1'b0;
          end else if (bit_cnt != 6'd55) begin
            sclk_out <= 1'b1;
            sr       <= {sr[46:0], miso_in};
            bit_cnt  <= bit_cnt + 6'd1;
          end
        end
        HOLD: if (tmr_done) begin
          cs_n_out <= 1'b1;
`ifdef GYRO_BIAS_EN
          if (cal_cnt != 5'd16) begin
            acc_x   <= acc_x + sext(raw_x);
            acc_y   <= acc_y + sext(raw_y);
            acc_z   <= acc_z + sext(raw_z);
            cal_cnt <= cal_cnt + 5'd1;
          end else begin
            gx        <= 16'(sext(raw_x) - (acc_x >>> 4));
            gy        <= 16'(sext(raw_y) - (acc_y >>> 4));
            gz        <= 16'(sext(raw_z) - (acc_z >>> 4));
            valid_out <= 1'b1;
          end
`else
          gx        <= raw_x;
          gy        <= raw_y;
          gz        <= raw_z;
          valid_out <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
